// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg: shared types and helpers for the divider sequencing controller.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A single-cycle settle still needs a one-bit counter.
  function automatic int cnt_width(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_result_check.sv
// ---------------------------------------------------------------------------
// div_result_check: flags a quotient/remainder pair that does not reproduce the dividend.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_result_check #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [DATA_WIDTH-1:0] quotient,
  input  logic [DATA_WIDTH-1:0] remainder,
  output logic                  err
);

  localparam int PW = 2 * DATA_WIDTH;

  // Double width holds q*d + r for any operands without wrapping.
  logic [PW-1:0] prod_sum;

  assign prod_sum = PW'(quotient) * PW'(divisor) + PW'(remainder);
  assign err      = (prod_sum != PW'(dividend)) || (remainder >= divisor);

endmodule

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl: registers operands into an external combinational divider, waits a
// fixed settle time, then captures and checks the result. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0] out_remainder,
  output logic                  out_div_by_zero,
  output logic                  out_check_err
);

  localparam int            CW       = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dvd_q, dvs_q, quo_q, rem_q;
  logic                    dz_q, err_q;
  logic                    accept, capture, zero_div, chk_err;

  assign zero_div = (in_divisor == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = zero_div ? S_DONE : S_WAIT;
          if (!zero_div) cnt_d = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n directly so nothing is accepted during reset.
  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
    capture   = (state_q == S_WAIT) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      dvd_q <= in_dividend;
      dvs_q <= in_divisor;
      if (zero_div) begin
        quo_q <= '1;
        rem_q <= in_dividend;
        dz_q  <= 1'b1;
        err_q <= 1'b0;
      end
    end else if (capture) begin
      quo_q <= div_quotient;
      rem_q <= div_remainder;
      dz_q  <= 1'b0;
      err_q <= chk_err;
    end
  end

  div_result_check #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_check (
    .dividend  (dvd_q),
    .divisor   (dvs_q),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .err       (chk_err)
  );

  assign div_dividend    = dvd_q;
  assign div_divisor     = dvs_q;
  assign out_quotient    = quo_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dz_q;
  assign out_check_err   = err_q;

endmodule

`default_nettype wire

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencing controller that sits on both sides of the team's combinational divider. It accepts operand pairs over a valid/ready handshake and drives the divider inputs from registers. After a fixed settle time it captures quotient and remainder and presents them downstream with backpressure. It also flags divide-by-zero and verifies every result arithmetically, so the fixed-iteration divider's saturating cases are caught at the source.

## Interface
- DATA_WIDTH, 8: operand/result width.
- SETTLE_CYCLES, 2: cycles the divider inputs are held before capture; legal range ≥1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept.
- in_dividend  in  DATA_WIDTH  dividend.
- in_divisor  in  DATA_WIDTH  divisor.
- div_dividend  out  DATA_WIDTH  registered dividend to divider.
- div_divisor  out  DATA_WIDTH  registered divisor to divider.
- div_quotient  in  DATA_WIDTH  divider quotient (combinational from div_*).
- div_remainder  in  DATA_WIDTH  divider remainder.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_quotient  out  DATA_WIDTH  captured quotient.
- out_remainder  out  DATA_WIDTH  captured remainder.
- out_div_by_zero  out  1  divisor was zero.
- out_check_err  out  1  result failed the arithmetic check.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - in_ready=1; in_ready is forced 0 while rst_n=0.
  - On in_valid&&in_ready: load div_dividend/div_divisor from in_*.
  - If in_divisor==0: go DONE with quotient all-ones, remainder=dividend, div_by_zero=1, check_err=0.
  - Otherwise: load settle counter with SETTLE_CYCLES-1 and go WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At counter==0: capture div_quotient/div_remainder, compute check, go DONE.
  - in_valid is ignored.
- Check:
  - check_err=1 if (q*d + r) != dividend, evaluated in 2*DATA_WIDTH bits with no truncation.
  - check_err=1 if r >= d.
  - q and r are the captured divider outputs; d and dividend are the registered operands.
- DONE:
  - out_valid=1; all out_* held stable while out_ready=0.
  - On out_ready: go IDLE.
  - in_ready=0, so there is no overlap between consecutive operations.
- div_dividend/div_divisor change only on acceptance and never while in WAIT.
- Reset values:
  - State: IDLE.
  - out_valid, in_ready, out_div_by_zero, out_check_err: 0.
  - out_quotient, out_remainder, div_dividend, div_divisor: 0.
  - Counter: 0.

## Timing
- Cycle 0 is the handshake cycle.
- div_* outputs carry the new operands from cycle 1.
- Normal path:
  - Capture edge closes cycle SETTLE_CYCLES.
  - out_valid high from cycle SETTLE_CYCLES+1.
  - Latency is SETTLE_CYCLES+1.
- Divide-by-zero path: out_valid high from cycle 1 (latency 1); the settle wait is skipped.
- Output handshake completes in the cycle out_valid&&out_ready; in_ready rises the next cycle.
- Peak throughput is one result per SETTLE_CYCLES+2 cycles with out_ready tied high.
- Reset mid-operation: the next edge with rst_n=0 aborts the operation and restores all reset values. No partial result is ever emitted.
- in_valid during reset is dropped.

## Structure
- Package div_seq_pkg holds:
  - the state enum typedef (IDLE/WAIT/DONE);
  - the settle counter width function, $clog2(SETTLE_CYCLES+1) with a minimum of 1.
- One sub-module, div_result_check: combinational, parameterised by DATA_WIDTH. Inputs dividend, divisor, quotient, remainder; output err, using the 2*DATA_WIDTH product-sum.
- The divider itself is instantiated by the parent, not inside this block.

## Test plan
- W=8, S=2. Offer 100/7; divider model returns 14/2. Required: out_valid in cycle 3, q=14, r=2, dz=0, err=0.
- Offer 55/0. Required: out_valid in cycle 1, q=0xFF, r=55, dz=1, err=0.
- Offer 200/3; divider model returns q=8, r=176 (saturated). Required: err=1, dz=0, values passed through unchanged.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands. Required: all out_* stable, in_ready=0, div_* unchanged. Release out_ready: IDLE next cycle, in_ready=1.
- Reset: assert rst_n=0 in cycle 1 of a 100/7 op. Required: after that edge, out_valid=0, div_*=0, in_ready=0 until rst_n=1, and no result ever appears.
- Back-to-back: hold in_valid high with 9/2 then 9/3 and out_ready=1. Required: results 4/1 then 3/0 in order, second accepted the cycle after the first out handshake, spacing 4 cycles.
